counter_sequencer: RTL and testbench

//   Command-driven controller for the up/down counter. It accepts {direction, step-count}

---
 rtl/counter_sequencer.sv | 79 +++++++
 tb/tb_counter_sequencer.sv | 134 +++++++++++++
 2 files changed

// File: rtl/counter_sequencer.sv
// counter_sequencer: runs {direction, step-count} commands against an up/down counter.
// Optional CNT_SEQ_BOUNCE_EN reverses direction at the counter limits instead of wrapping.
module counter_sequencer #(
  parameter int CNT_W  = 4,
  parameter int STEP_W = 8
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_up,
  input  logic [STEP_W-1:0] cmd_steps,
  input  logic              abort,
  input  logic [CNT_W-1:0]  cnt_value,
  output logic              cnt_enable,
  output logic              cnt_up_down,
  output logic              busy,
  output logic              done,
  output logic              aborted,
  output logic [STEP_W-1:0] steps_left
);
  typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;
  state_t state, state_n;
  logic dir_q, dir_n, aborted_n;
  logic [STEP_W-1:0] steps_n;
  logic accept;
  assign accept     = cmd_valid & cmd_ready;
  assign cmd_ready  = state == IDLE;
  assign busy       = state != IDLE;
  assign cnt_enable = state == RUN;
  assign done       = state == DONE;
`ifdef CNT_SEQ_BOUNCE_EN
  logic at_lim;
  assign at_lim      = dir_q ? (cnt_value == '1) : (cnt_value == '0);
  assign cnt_up_down = (state == RUN) ? dir_q ^ at_lim : dir_q;
`else
  logic unused_cnt;
  assign unused_cnt  = ^cnt_value;
  assign cnt_up_down = dir_q;
`endif
  always_comb begin
    state_n   = state;
    dir_n     = dir_q;
    steps_n   = steps_left;
    aborted_n = 1'b0;
    case (state)
      IDLE: if (accept) begin
        state_n = (cmd_steps != '0) ? RUN : DONE;
        dir_n   = cmd_up;
        steps_n = cmd_steps;
      end
      RUN: begin
        dir_n   = cnt_up_down;
        steps_n = steps_left - 1'b1;
        // abort takes priority over completion of the last step
        if (abort) begin
          state_n   = IDLE;
          steps_n   = '0;
          aborted_n = 1'b1;
        end else if (steps_left == 1) state_n = DONE;
      end
      DONE:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      dir_q      <= 1'b0;
      steps_left <= '0;
      aborted    <= 1'b0;
    end else begin
      state      <= state_n;
      dir_q      <= dir_n;
      steps_left <= steps_n;
      aborted    <= aborted_n;
    end
  end
endmodule

// File: tb/tb_counter_sequencer.sv
// tb_counter_sequencer: drives command vectors through the sequencer with a live counter plant.
module tb_counter_sequencer;
`ifdef CNT_SEQ_BOUNCE_EN
  localparam bit B = 1'b1;
`else
  localparam bit B = 1'b0;
`endif
  logic clock, reset, plant_rst_n;
  logic cmd_valid, cmd_ready, cmd_up, abort;
  logic [7:0] cmd_steps, steps_left;
  logic [3:0] cnt_value;
  logic cnt_enable, cnt_up_down, busy, done, aborted;

  counter_sequencer #(.CNT_W(4), .STEP_W(8)) dut (
    .clock(clock), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_up(cmd_up), .cmd_steps(cmd_steps), .abort(abort), .cnt_value(cnt_value),
    .cnt_enable(cnt_enable), .cnt_up_down(cnt_up_down), .busy(busy), .done(done),
    .aborted(aborted), .steps_left(steps_left)
  );

  always_ff @(posedge clock or negedge plant_rst_n)
    if (!plant_rst_n) cnt_value <= '0;
    else if (cnt_enable) cnt_value <= cnt_up_down ? cnt_value + 4'd1 : cnt_value - 4'd1;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    bit up; int steps; int abort_at; int exp_cnt; bit exp_done; bit exp_abt; int exp_edges;
  } vec_t;
  vec_t tbl[7];
  vec_t sb[$];
  int n_vec = 0, n_err = 0;

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic run_vec(input vec_t v, input string nm);
    int edges, lat;
    vec_t e;
    @(negedge clock);
    chk({nm, " ready"}, int'(cmd_ready), 1);
    cmd_valid = 1'b1;
    cmd_up    = v.up;
    cmd_steps = v.steps[7:0];
    sb.push_back(v);
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    if (v.steps != 0) chk({nm, " steps_left"}, int'(steps_left), v.steps);
    edges = 0;
    lat   = 1;
    while (!(done || aborted) && lat < 300) begin
      if (cnt_enable) begin
        edges++;
        abort = (v.abort_at != 0) && (edges == v.abort_at);
      end else abort = 1'b0;
      @(negedge clock);
      lat++;
    end
    abort = 1'b0;
    if (lat >= 300) chk({nm, " timeout"}, lat, 0);
    e = sb.pop_front();
    chk({nm, " cnt_value"}, int'(cnt_value), e.exp_cnt);
    chk({nm, " done"}, int'(done), int'(e.exp_done));
    chk({nm, " aborted"}, int'(aborted), int'(e.exp_abt));
    chk({nm, " enable_edges"}, edges, e.exp_edges);
    chk({nm, " latency"}, lat, e.exp_edges + 1);
    chk({nm, " end steps_left"}, int'(steps_left), 0);
    chk({nm, " ready_at_end"}, int'(cmd_ready), e.exp_done ? 0 : 1);
    @(negedge clock);
    chk({nm, " pulse_done"}, int'(done), 0);
    chk({nm, " pulse_abt"}, int'(aborted), 0);
    chk({nm, " ready_after"}, int'(cmd_ready), 1);
    chk({nm, " cnt_held"}, int'(cnt_value), e.exp_cnt);
  endtask

  initial begin
    int held;
    tbl[0] = '{1'b1, 5, 0, 5, 1'b1, 1'b0, 5};
    tbl[1] = '{1'b0, 4, 0, 1, 1'b1, 1'b0, 4};
    tbl[2] = '{1'b0, 3, 0, B ? 2 : 14, 1'b1, 1'b0, 3};
    tbl[3] = '{1'b1, 0, 0, B ? 2 : 14, 1'b1, 1'b0, 0};
    tbl[4] = '{1'b1, 10, 4, B ? 6 : 2, 1'b0, 1'b1, 4};
    tbl[5] = '{1'b1, B ? 7 : 11, 0, 13, 1'b1, 1'b0, B ? 7 : 11};
    tbl[6] = '{1'b1, 6, 0, B ? 11 : 3, 1'b1, 1'b0, 6};
    reset = 1'b0; plant_rst_n = 1'b0;
    cmd_valid = 1'b0; cmd_up = 1'b0; cmd_steps = '0; abort = 1'b0;
    #12;
    chk("rst cnt_enable", int'(cnt_enable), 0);
    chk("rst cmd_ready", int'(cmd_ready), 1);
    chk("rst busy", int'(busy), 0);
    chk("rst done", int'(done), 0);
    chk("rst aborted", int'(aborted), 0);
    chk("rst steps_left", int'(steps_left), 0);
    chk("rst cnt_value", int'(cnt_value), 0);
    @(negedge clock);
    reset = 1'b1; plant_rst_n = 1'b1;
    abort = 1'b1;
    @(negedge clock);
    abort = 1'b0;
    chk("idle abort aborted", int'(aborted), 0);
    chk("idle abort busy", int'(busy), 0);
    chk("idle hold cnt", int'(cnt_value), 0);
    for (int i = 0; i < 7; i++) run_vec(tbl[i], $sformatf("vec%0d", i));
    @(negedge clock);
    held = int'(cnt_value);
    cmd_valid = 1'b1; cmd_up = 1'b1; cmd_steps = 8'd8;
    @(posedge clock);
    @(negedge clock);
    cmd_valid = 1'b0;
    @(negedge clock);
    @(negedge clock);
    #2 reset = 1'b0;
    #1;
    chk("midrst busy", int'(busy), 0);
    chk("midrst cnt_enable", int'(cnt_enable), 0);
    chk("midrst cmd_ready", int'(cmd_ready), 1);
    chk("midrst steps_left", int'(steps_left), 0);
    chk("midrst cnt", int'(cnt_value), (held + 2) % 16);
    @(negedge clock);
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk("midrst hold", int'(cnt_value), (held + 2) % 16);
    chk("midrst idle", int'(busy), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
